// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master) and memory (slave).
// Word-aligned req/ack handshake with byte enables; ack is a one-cycle pulse.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues one bus transaction per access, stalls the
// pipeline until ack, and returns the lane-extracted, extended load result.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              err_o,
  output logic [31:0]       read_data_o,
  mem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              load_q, load_d;

  logic        want;
  logic        legal;
  logic        acc;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_v;

  assign want = (mem_read_i | mem_write_i) & ~flush_i;

  // A request with both read and write set is a store, so load-only sizes are illegal.
  always_comb begin
    legal = 1'b0;
    case (funct3_i)
      3'b000:         legal = 1'b1;
      3'b001:         legal = ~addr_i[0];
      3'b010:         legal = (addr_i[1:0] == 2'b00);
      3'b100:         legal = ~mem_write_i;
      3'b101:         legal = ~mem_write_i & ~addr_i[0];
      default:        legal = 1'b0;
    endcase
  end

  assign acc     = (state_q == IDLE) & want & legal;
  assign err_o   = (state_q == IDLE) & want & ~legal;
  assign stall_o = acc | (state_q == BUSY);

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata_i[31:0];
    case (funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_v = bus.mem_rdata[{off_q, 3'b000} +: 8];
    half_v = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  ext_v = {24'd0, byte_v};
      3'b001:  ext_v = {{16{half_v[15]}}, half_v};
      3'b101:  ext_v = {16'd0, half_v};
      default: ext_v = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = mem_write_i;
          addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          f3_d    = funct3_i;
          off_d   = addr_i[1:0];
          load_d  = mem_read_i & ~mem_write_i;
        end
      end
      BUSY: begin
        // Address and data stay registered after ack; only the strobes drop.
        if (bus.mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          if (load_q) rdata_d = ext_v;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      load_q  <= load_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign read_data_o   = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: drivers push expected bus/result items,
// a negedge monitor pops and compares them as the DUT presents requests and load data.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        err_o;
  logic [31:0] read_data_o;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .stall_o     (stall_o),
    .err_o       (err_o),
    .read_data_o (read_data_o),
    .bus         (bus.master)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] res_q[$];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic is_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic ok_size;
    if (wr) ok_size = (f3 <= 3'd2);
    else    ok_size = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return ok_size && ((a % nbytes(f3)) == 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    m = 4'((1 << nbytes(f3)) - 1);
    return m << a[1:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (nbytes(f3) == 1) return {24'd0, w[7:0]} * 32'h01010101;
    if (nbytes(f3) == 2) return {16'd0, w[15:0]} * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] r);
    int          n;
    logic [31:0] v, mask;
    n = nbytes(f3);
    if (n == 4) return r;
    v    = r >> (8 * a[1:0]);
    mask = (32'h1 << (8 * n)) - 32'h1;
    v    = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- monitor ----------------
  logic req_prev = 1'b0;
  logic ack_hit  = 1'b0;
  bus_t mon_e;

  always @(negedge clk) begin
    if (ack_hit) begin
      if (res_q.size() == 0) chk("result_underflow", 32'd1, 32'd0);
      else                   chk("read_data", read_data_o, res_q.pop_front());
    end
    ack_hit = bus.mem_ack && bus.mem_req && !rst_i;
    if (bus.mem_req && !req_prev) begin
      if (bus_q.size() == 0) chk("bus_underflow", 32'd1, 32'd0);
      else begin
        mon_e = bus_q.pop_front();
        chk("bus_we",    {31'd0, bus.mem_we}, {31'd0, mon_e.we});
        chk("bus_addr",  bus.mem_addr, mon_e.addr);
        chk("bus_be",    {28'd0, bus.mem_be}, {28'd0, mon_e.be});
        chk("bus_wdata", bus.mem_wdata, mon_e.wdata);
      end
    end
    req_prev = bus.mem_req;
  end

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    flush_i     = 1'b0;
    funct3_i    = 3'd0;
    addr_i      = 32'd0;
    wdata_i     = 32'd0;
  endtask

  // Called just after a posedge with the DUT in IDLE; returns just after the edge leaving DONE.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] w, input logic [31:0] r,
                        input int k, input logic fl_busy);
    int st;
    bus_q.push_back('{we: wr, addr: {a[31:2], 2'b00}, be: exp_be(f3, a), wdata: exp_wdata(f3, w)});
    if (rd && !wr) last_rd = extract(f3, a, r);
    res_q.push_back(last_rd);
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = w; flush_i = 1'b0;
    @(negedge clk);
    chk("err_on_issue", {31'd0, err_o}, 32'd0);
    st = int'(stall_o);
    for (int i = 1; i <= k; i++) begin
      @(posedge clk); #1;
      if (fl_busy) flush_i = 1'b1;
      if (i == k) begin bus.mem_ack = 1'b1; bus.mem_rdata = r; end
      else        bus.mem_rdata = $urandom;
      @(negedge clk);
      chk("req_held_busy", {31'd0, bus.mem_req}, 32'd1);
      st += int'(stall_o);
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
    @(negedge clk);
    chk("stall_in_done", {31'd0, stall_o}, 32'd0);
    chk("stall_cycles", st, k + 1);
    chk("req_after_ack", {31'd0, bus.mem_req}, 32'd0);
    chk("be_after_ack", {28'd0, bus.mem_be}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // Request that must not reach the bus (illegal or flushed in IDLE).
  task automatic no_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic fl);
    logic exp_err;
    exp_err = !fl && !is_legal(wr, f3, a);
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; flush_i = fl;
    wdata_i = $urandom;
    bus.mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("err_flag", {31'd0, err_o}, {31'd0, exp_err});
    chk("stall_no_access", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("req_no_access", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic        rd, wr, fl;
    logic [2:0]  f3;
    logic [31:0] a;
    int          sel;
    clear_inputs();
    last_rd       = 32'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    rst_i         = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_req",   {31'd0, bus.mem_req}, 32'd0);
    chk("rst_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst_addr",  bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_be",    {28'd0, bus.mem_be}, 32'd0);
    chk("rst_rdata", read_data_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_err",   {31'd0, err_o}, 32'd0);
    @(posedge clk); #1;

    // Reset while BUSY, then a stray ack
    bus_q.push_back('{we: 1'b0, addr: 32'h40, be: 4'hF, wdata: 32'h0});
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h40;
    @(posedge clk);
    @(negedge clk);
    chk("busy_before_rst", {31'd0, bus.mem_req}, 32'd1);
    #1 rst_i = 1'b1;
    #1 chk("rst_async_req", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_rdata", read_data_o, 32'd0);
    chk("stray_ack_req", {31'd0, bus.mem_req}, 32'd0);
    chk("stray_ack_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;

    // Directed cases
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0);
    access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 1, 1'b0);
    chk("lb_value", last_rd, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h80112233, 2, 1'b0);
    chk("lhu_value", last_rd, 32'h00008011);
    access(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000AB, 32'h0, 1, 1'b0);
    access(1'b0, 1'b1, 3'b001, 32'h302, 32'h00001234, 32'h0, 2, 1'b0);
    no_access(1'b1, 1'b0, 3'b010, 32'h102, 1'b0);
    no_access(1'b1, 1'b0, 3'b010, 32'h100, 1'b1);
    access(1'b0, 1'b1, 3'b010, 32'h400, 32'h11223344, 32'h0, 1, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'h55667788, 1, 1'b1);
    access(1'b1, 1'b1, 3'b010, 32'h408, 32'h99AABBCC, 32'h12345678, 1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 7);
      rd  = (sel <= 3) || (sel == 7);
      wr  = (sel >= 4);
      if ($urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end else f3 = 3'($urandom);
      a = $urandom;
      if ($urandom_range(0, 9) < 7) a = a & ~32'(nbytes(f3) - 1);
      fl = ($urandom_range(0, 9) == 0);
      if (!fl && is_legal(wr, f3, a))
        access(rd, wr, f3, a, $urandom, $urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      else
        no_access(rd, wr, f3, a, fl);
    end

    repeat (2) @(posedge clk);
    chk("bus_queue_drained", bus_q.size(), 32'd0);
    chk("result_queue_drained", res_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
